// File: rtl/lvds_video_pkg.sv
// Shared definitions for the LVDS video timing generator: pattern codes,
// colour-bar palette and FSM state encoding.
package lvds_video_pkg;

    localparam logic [2:0] PAT_BARS  = 3'd0;
    localparam logic [2:0] PAT_RAMP  = 3'd1;
    localparam logic [2:0] PAT_CHECK = 3'd2;
    localparam logic [2:0] PAT_WHITE = 3'd3;
    localparam logic [2:0] PAT_RED   = 3'd4;

    localparam logic [23:0] COL_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] COL_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] COL_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] COL_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] COL_RED     = 24'hFF_00_00;
    localparam logic [23:0] COL_BLUE    = 24'h00_00_FF;
    localparam logic [23:0] COL_BLACK   = 24'h00_00_00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lvds_pattern_gen.sv
// Combinational test-pattern source; the caller gates the result with
// data-enable and registers it.
module lvds_pattern_gen (
    input  logic [7:0]  x,
    input  logic        y_tile,
    input  logic [2:0]  bar_idx,
    input  logic [7:0]  frame_cnt,
    input  logic [2:0]  pattern,
    output logic [23:0] rgb
);
    import lvds_video_pkg::*;

    // y_tile is bit 5 of the line counter; only that bit feeds the checkerboard
    always_comb begin
        rgb = COL_BLACK;
        case (pattern)
            PAT_BARS:  rgb = bar_colour(bar_idx);
            PAT_RAMP:  rgb = {x, x, x};
            PAT_CHECK: rgb = (x[5] ^ y_tile) ? COL_WHITE : COL_BLACK;
            PAT_WHITE: rgb = COL_WHITE;
            PAT_RED:   rgb = {frame_cnt, 16'h0000};
            default:   rgb = COL_BLACK;
        endcase
    end

endmodule

// File: rtl/lvds_video_timing_gen.sv
// Video timing generator for an LVDS transmitter: h/v counters, run/idle
// sequencing and registered timing plus test-pattern pixel outputs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | counters held at 0, outputs at idle levels, waiting for I_en
//   ST_RUN  | frames generated back to back; leaves only at frame wrap
module lvds_video_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic       I_pix_clk,
    input  logic       I_rst_n,
    input  logic       I_en,
    input  logic [2:0] I_pattern_sel,
    output logic       O_vs,
    output logic       O_hs,
    output logic       O_de,
    output logic [7:0] O_data_r,
    output logic [7:0] O_data_g,
    output logic [7:0] O_data_b,
    output logic       O_frame_start,
    output logic       O_busy
);
    import lvds_video_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_CW    = $clog2(H_TOTAL);
    localparam int V_CW    = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [H_CW-1:0]   H_LAST       = H_CW'(H_TOTAL - 1);
    localparam logic [H_CW-1:0]   H_ACT_END    = H_CW'(H_ACTIVE);
    localparam logic [H_CW-1:0]   H_SYNC_START = H_CW'(H_ACTIVE + H_FP);
    localparam logic [H_CW-1:0]   H_SYNC_END   = H_CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_CW-1:0]   V_LAST       = V_CW'(V_TOTAL - 1);
    localparam logic [V_CW-1:0]   V_ACT_END    = V_CW'(V_ACTIVE);
    localparam logic [V_CW-1:0]   V_SYNC_START = V_CW'(V_ACTIVE + V_FP);
    localparam logic [V_CW-1:0]   V_SYNC_END   = V_CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_CW-1:0]   V_BIT5       = V_CW'(32);
    localparam logic [BAR_CW-1:0] BAR_LOAD     = BAR_CW'(BAR_W - 1);

    logic [1:0]        rst_sync;
    logic              rst_n;
    state_t            state, state_nxt;
    logic [H_CW-1:0]   h_cnt;
    logic [V_CW-1:0]   v_cnt;
    logic [BAR_CW-1:0] bar_rem;
    logic [2:0]        bar_idx;
    logic [7:0]        frame_cnt;
    logic [2:0]        pat_q;
    logic              run;
    logic              h_wrap;
    logic              frame_wrap;
    logic              de_c;
    logic              hs_c;
    logic              vs_c;
    logic [23:0]       rgb;

    // Assertion is asynchronous; release is delayed by two pixel clocks
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign run        = (state == ST_RUN);
    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = run && h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge I_pix_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (I_en)                state_nxt = ST_RUN;
            ST_RUN:  if (frame_wrap && !I_en) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // bar_rem is a down-counter over one bar width; bar_idx steps at terminal count
    always_ff @(posedge I_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            bar_rem   <= BAR_LOAD;
            bar_idx   <= 3'd0;
            frame_cnt <= 8'd0;
            pat_q     <= PAT_BARS;
        end else if (!run) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            bar_rem   <= BAR_LOAD;
            bar_idx   <= 3'd0;
            frame_cnt <= 8'd0;
            if (I_en) pat_q <= I_pattern_sel;
        end else if (h_wrap) begin
            h_cnt   <= '0;
            bar_rem <= BAR_LOAD;
            bar_idx <= 3'd0;
            if (v_cnt == V_LAST) begin
                v_cnt     <= '0;
                frame_cnt <= frame_cnt + 8'd1;
                pat_q     <= I_pattern_sel;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
            if (bar_rem == '0) begin
                bar_rem <= BAR_LOAD;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_rem <= bar_rem - 1'b1;
            end
        end
    end

    lvds_pattern_gen u_pattern_gen (
        .x         (8'(h_cnt)),
        .y_tile    (|(v_cnt & V_BIT5)),
        .bar_idx   (bar_idx),
        .frame_cnt (frame_cnt),
        .pattern   (pat_q),
        .rgb       (rgb)
    );

    assign de_c = run && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs_c = run && (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    assign vs_c = run && (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

    always_ff @(posedge I_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            O_de          <= 1'b0;
            O_hs          <= ~SYNC_POL;
            O_vs          <= ~SYNC_POL;
            O_data_r      <= 8'h00;
            O_data_g      <= 8'h00;
            O_data_b      <= 8'h00;
            O_frame_start <= 1'b0;
            O_busy        <= 1'b0;
        end else begin
            O_de          <= de_c;
            O_hs          <= hs_c ? SYNC_POL : ~SYNC_POL;
            O_vs          <= vs_c ? SYNC_POL : ~SYNC_POL;
            O_data_r      <= de_c ? rgb[23:16] : 8'h00;
            O_data_g      <= de_c ? rgb[15:8]  : 8'h00;
            O_data_b      <= de_c ? rgb[7:0]   : 8'h00;
            O_frame_start <= run && (h_cnt == '0) && (v_cnt == '0);
            O_busy        <= run;
        end
    end

endmodule

// File: tb/tb_lvds_video_timing_gen.sv
// Directed bench for lvds_video_timing_gen using a 24x8 total raster
// (16x4 active) so whole frames can be checked pixel by pixel.
module tb_lvds_video_timing_gen;

    localparam int HT = 24;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] sel;
    logic       vs, hs, de;
    logic [7:0] dr, dg, db;
    logic       fs, busy;

    int n_cmp = 0;
    int n_err = 0;

    lvds_video_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1)
    ) dut (
        .I_pix_clk     (clk),
        .I_rst_n       (rst_n),
        .I_en          (en),
        .I_pattern_sel (sel),
        .O_vs          (vs),
        .O_hs          (hs),
        .O_de          (de),
        .O_data_r      (dr),
        .O_data_g      (dg),
        .O_data_b      (db),
        .O_frame_start (fs),
        .O_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] exp_rgb(input logic [2:0] pat, input int x, input int y,
                                            input logic [7:0] fc);
        logic [7:0] xb;
        xb = x[7:0];
        case (pat)
            3'd0: case (x / 2)
                      0: return 24'hFFFFFF;
                      1: return 24'hFFFF00;
                      2: return 24'h00FFFF;
                      3: return 24'h00FF00;
                      4: return 24'hFF00FF;
                      5: return 24'hFF0000;
                      6: return 24'h0000FF;
                      default: return 24'h000000;
                  endcase
            3'd1: return {xb, xb, xb};
            3'd2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            3'd3: return 24'hFFFFFF;
            3'd4: return {fc, 16'h0000};
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        n_cmp++;
        if ({de, hs, vs, fs, busy} !== 5'b00000) begin
            n_err++;
            $display("FAIL %s idle ctl got de/hs/vs/fs/busy=%b want 00000", tag, {de, hs, vs, fs, busy});
        end
        n_cmp++;
        if ({dr, dg, db} !== 24'h0) begin
            n_err++;
            $display("FAIL %s idle data got %h want 000000", tag, {dr, dg, db});
        end
    endtask

    task automatic wait_fs(input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fs === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL wait_fs no frame_start within %0d cycles", budget);
        end
    endtask

    // Checks nf whole frames, starting at the negedge where frame_start is high.
    task automatic run_check(input int nf, input logic [2:0] pat_first, input logic [2:0] pat_next,
                             input int sel_k, input logic [2:0] sel_v,
                             input int en_k, input logic en_v);
        int f, k, h, v;
        int de_n, hs_n, vs_n, fs_n;
        logic [2:0] pat;
        logic e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
        for (int n = 0; n < nf * FT; n++) begin
            if (n > 0) @(negedge clk);
            f = n / FT;
            k = n % FT;
            h = k % HT;
            v = k / HT;
            pat   = (f == 0) ? pat_first : pat_next;
            e_de  = (h < 16) && (v < 4);
            e_hs  = (h >= 18) && (h <= 20);
            e_vs  = (v == 5) || (v == 6);
            e_fs  = (k == 0);
            e_rgb = e_de ? exp_rgb(pat, h, v, 8'(f)) : 24'h0;
            de_n += int'(de); hs_n += int'(hs); vs_n += int'(vs); fs_n += int'(fs);
            n_cmp++;
            if ({de, hs, vs, fs, busy} !== {e_de, e_hs, e_vs, e_fs, 1'b1}) begin
                n_err++;
                $display("FAIL timing f=%0d h=%0d v=%0d got de/hs/vs/fs/busy=%b want %b",
                         f, h, v, {de, hs, vs, fs, busy}, {e_de, e_hs, e_vs, e_fs, 1'b1});
            end
            n_cmp++;
            if ({dr, dg, db} !== e_rgb) begin
                n_err++;
                $display("FAIL pixel pat=%0d f=%0d h=%0d v=%0d got %h want %h",
                         pat, f, h, v, {dr, dg, db}, e_rgb);
            end
            if (k == FT - 1) begin
                n_cmp++;
                if (de_n != 64 || hs_n != 24 || vs_n != 48 || fs_n != 1) begin
                    n_err++;
                    $display("FAIL frame_counts f=%0d got de=%0d hs=%0d vs=%0d fs=%0d want 64/24/48/1",
                             f, de_n, hs_n, vs_n, fs_n);
                end
                de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
            end
            if (n == sel_k) sel = sel_v;
            if (n == en_k)  en  = en_v;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sel = 3'd0;
        repeat (4) @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic test_bars_timing();
        sel = 3'd0;
        en  = 1'b1;
        wait_fs(10);
        // pattern change late in the third frame only takes effect on the next frame
        run_check(3, 3'd0, 3'd0, 2 * FT + 100, 3'd3, -1, 1'b1);
    endtask

    task automatic test_pattern_change();
        wait_fs(10);
        run_check(2, 3'd3, 3'd2, 2 * HT, 3'd2, -1, 1'b1);
    endtask

    task automatic test_en_drop();
        wait_fs(10);
        run_check(1, 3'd2, 3'd2, -1, 3'd0, HT, 1'b0);
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (i % 50 == 0) check_idle("en_drop");
            n_cmp++;
            if (fs !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL en_drop_quiet i=%0d got fs=%b busy=%b want 0 0", i, fs, busy);
            end
        end
    endtask

    task automatic test_ramp();
        sel = 3'd1;
        en  = 1'b1;
        wait_fs(10);
        run_check(1, 3'd1, 3'd1, -1, 3'd0, HT, 1'b0);
        repeat (3) @(negedge clk);
        check_idle("ramp_end");
    endtask

    task automatic test_red_reset();
        sel = 3'd4;
        en  = 1'b1;
        wait_fs(10);
        run_check(3, 3'd4, 3'd4, -1, 3'd0, -1, 1'b1);
        repeat (2 * HT + 3) @(negedge clk);
        n_cmp++;
        if (de !== 1'b1 || dr !== 8'h03) begin
            n_err++;
            $display("FAIL red_frame3 got de=%b r=%h want 1 03", de, dr);
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(20);
        run_check(1, 3'd4, 3'd4, -1, 3'd0, HT, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 3'd0;
        test_reset();
        test_bars_timing();
        test_pattern_change();
        test_en_drop();
        test_ramp();
        test_red_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
